// File: rtl/uart_msg_framer.sv
// Frames buffered payload as SYNC, count, escaped body (+SP_END tail if MSGFRAMER_TAIL_EN) into a UART TX.
// First load one cycle after send; one byte in flight, each load waits for tx_empty high then its drop.
module uart_msg_framer #(
  parameter int unsigned DATAMAXBYTES = 10,
  parameter logic [7:0]  SP_SYNC      = 8'h7E,
  parameter logic [7:0]  SP_ESC       = 8'hFE,
  parameter logic [7:0]  SP_END       = 8'h03
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic [7:0] tx_data,
  output logic       ld_tx_data,
  input  logic       tx_empty
);

  localparam int         AW     = (DATAMAXBYTES > 1) ? $clog2(DATAMAXBYTES) : 1;
  localparam logic [7:0] MAXCNT = 8'(DATAMAXBYTES);

  typedef enum logic [2:0] {IDLE, SYNC, BCNT, BODY, ESC, TAIL, WACK, DONE} state_t;

`ifdef MSGFRAMER_TAIL_EN
  localparam state_t END_ST = TAIL;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t     state;
  state_t     cont;
  state_t     pend_next;
  logic [7:0] mem [DATAMAXBYTES];
  logic [7:0] count;
  logic [7:0] idx;
  logic [7:0] pend_byte;
  logic       pend_body;

  logic       wr_ok;
  logic [7:0] body_byte;
  logic       body_last;

  function automatic logic is_special(input logic [7:0] b);
    return (b == SP_SYNC) || (b == SP_ESC);
  endfunction

  assign wr_ok     = (state == IDLE) && wr_en && !send && (count < MAXCNT);
  assign body_byte = mem[idx[AW-1:0]];
  assign body_last = (idx + 8'd1) >= count;
  assign wr_full   = (count == MAXCNT);

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cont       <= IDLE;
      pend_next  <= IDLE;
      pend_byte  <= 8'h00;
      pend_body  <= 1'b0;
      count      <= 8'd0;
      idx        <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ld_tx_data <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      ld_tx_data <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            busy <= 1'b1;
            idx  <= 8'd0;
            // SYNC goes out straight from IDLE when the UART is ready, giving one-cycle send latency
            if (tx_empty) begin
              ld_tx_data <= 1'b1;
              tx_data    <= SP_SYNC;
              cont       <= BCNT;
              state      <= WACK;
            end else begin
              state <= SYNC;
            end
          end else if (wr_ok) begin
            count <= count + 8'd1;
          end
        end
        SYNC: if (tx_empty) begin
          ld_tx_data <= 1'b1;
          tx_data    <= SP_SYNC;
          cont       <= BCNT;
          state      <= WACK;
        end
        BCNT: if (tx_empty) begin
          ld_tx_data <= 1'b1;
          state      <= WACK;
          if (is_special(count)) begin
            tx_data   <= SP_ESC;
            cont      <= ESC;
            pend_byte <= count;
            pend_body <= 1'b0;
            pend_next <= (count == 8'd0) ? END_ST : BODY;
          end else begin
            tx_data <= count;
            cont    <= (count == 8'd0) ? END_ST : BODY;
          end
        end
        BODY: if (tx_empty) begin
          ld_tx_data <= 1'b1;
          state      <= WACK;
          if (is_special(body_byte)) begin
            tx_data   <= SP_ESC;
            cont      <= ESC;
            pend_byte <= body_byte;
            pend_body <= 1'b1;
            pend_next <= body_last ? END_ST : BODY;
          end else begin
            tx_data <= body_byte;
            idx     <= idx + 8'd1;
            cont    <= body_last ? END_ST : BODY;
          end
        end
        ESC: if (tx_empty) begin
          // raw byte after the prefix; only body bytes advance the read index
          ld_tx_data <= 1'b1;
          tx_data    <= pend_byte;
          cont       <= pend_next;
          state      <= WACK;
          if (pend_body) idx <= idx + 8'd1;
        end
        TAIL: if (tx_empty) begin
          ld_tx_data <= 1'b1;
          tx_data    <= SP_END;
          cont       <= DONE;
          state      <= WACK;
        end
        WACK: if (!tx_empty) state <= cont;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          count <= 8'd0;
          idx   <= 8'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_framer.sv
// Directed bench for uart_msg_framer with a UART TX model (tx_empty drops after a load, rises ~10 cycles later).
module tb_uart_msg_framer;
  logic       CLK = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       send;
  logic       busy;
  logic       done;
  logic [7:0] tx_data;
  logic       ld_tx_data;
  logic       tx_empty = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int   viol = 0;
  int   done_cnt = 0;
  int   cnt = 0;
  logic hold = 1'b0;
  logic prev_ld = 1'b0;

  always #5 CLK = ~CLK;

  uart_msg_framer dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .send(send), .busy(busy), .done(done), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .tx_empty(tx_empty)
  );

  // UART model and protocol monitor, sampling mid-cycle
  always @(negedge CLK) begin
    if (done) begin
      done_cnt++;
      if (busy) viol++;
    end
    if (ld_tx_data) begin
      if (!tx_empty || prev_ld) viol++;
      got.push_back(tx_data);
    end
    prev_ld = ld_tx_data;
    if (hold) begin
      tx_empty = 1'b0;
      cnt = 0;
    end else if (ld_tx_data) begin
      tx_empty = 1'b0;
      cnt = 10;
    end else if (!tx_empty) begin
      if (cnt <= 1) tx_empty = 1'b1;
      else cnt--;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic settle();
    int i;
    for (i = 0; i < 50; i++) begin
      if (tx_empty) break;
      tick(1);
    end
    checks++;
    if (i >= 50) begin
      errors++;
      $display("FAIL settle tx_empty=%0b want 1 within 50 cycles", tx_empty);
    end
    tick(2);
  endtask

  task automatic send_wait(input logic busy_wr, input logic [7:0] bw_data,
                           output logic first_ld, output logic [7:0] first_dat,
                           output logic first_busy, output logic ok);
    send = 1'b1;
    tick(1);
    send = 1'b0;
    wr_en = 1'b0;
    first_ld = ld_tx_data;
    first_dat = tx_data;
    first_busy = busy;
    if (busy_wr) write_byte(bw_data);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0;
    tick(3);
    checks++; if (ld_tx_data !== 1'b0) begin errors++; $display("FAIL rst_ld got %b want 0", ld_tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_txdata got %h want 00", tx_data); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", wr_full); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    logic [7:0] exp[$];
    logic fl, fb, ok;
    logic [7:0] fd;
    int base = got.size();
    int dc = done_cnt;
    write_byte(8'h41); write_byte(8'h42); write_byte(8'h43);
    wr_en = 1'b1; wr_data = 8'h44;  // collides with send; must be dropped
    send_wait(1'b0, 8'h00, fl, fd, fb, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_done_timeout got %b want 1", ok); end
    checks++; if (fl !== 1'b1 || fd !== 8'h7E) begin errors++; $display("FAIL t1_latency ld=%b data=%h want 1/7e", fl, fd); end
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL t1_busy_rise got %b want 1", fb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_fall got %b want 0", busy); end
    settle();
    exp = '{8'h7E, 8'h03, 8'h41, 8'h42, 8'h43};
`ifdef MSGFRAMER_TAIL_EN
    exp.push_back(8'h03);
`endif
    checks++;
    if (got.size() - base !== exp.size()) begin errors++; $display("FAIL t1_len got %0d want %0d", got.size() - base, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL t1_byte%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL t1_done_pulses got %0d want 1", done_cnt - dc); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL t1_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_escape();
    logic [7:0] exp[$];
    logic fl, fb, ok;
    logic [7:0] fd;
    int base = got.size();
    write_byte(8'h7E); write_byte(8'hFE);
    send_wait(1'b0, 8'h00, fl, fd, fb, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t2_done_timeout got %b want 1", ok); end
    settle();
    exp = '{8'h7E, 8'h02, 8'hFE, 8'h7E, 8'hFE, 8'hFE};
`ifdef MSGFRAMER_TAIL_EN
    exp.push_back(8'h03);
`endif
    checks++;
    if (got.size() - base !== exp.size()) begin errors++; $display("FAIL t2_len got %0d want %0d", got.size() - base, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL t2_byte%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL t2_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_full();
    logic [7:0] exp[$];
    logic fl, fb, ok;
    logic [7:0] fd;
    int base = got.size();
    for (int i = 0; i < 10; i++) write_byte(8'(8'h30 + i));
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL t3_full got %b want 1", wr_full); end
    write_byte(8'h55);
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL t3_full_hold got %b want 1", wr_full); end
    send_wait(1'b1, 8'h66, fl, fd, fb, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t3_done_timeout got %b want 1", ok); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL t3_full_clear got %b want 0", wr_full); end
    settle();
    exp = '{8'h7E, 8'h0A};
    for (int i = 0; i < 10; i++) exp.push_back(8'(8'h30 + i));
`ifdef MSGFRAMER_TAIL_EN
    exp.push_back(8'h03);
`endif
    checks++;
    if (got.size() - base !== exp.size()) begin errors++; $display("FAIL t3_len got %0d want %0d", got.size() - base, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL t3_byte%0d got %h want %h", i, got[base+i], exp[i]); end
    end
  endtask

  // Runs straight after test_full: a non-empty frame here means a dropped write leaked in.
  task automatic test_empty();
    logic [7:0] exp[$];
    logic fl, fb, ok;
    logic [7:0] fd;
    int base = got.size();
    int dc = done_cnt;
    send_wait(1'b0, 8'h00, fl, fd, fb, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t4_done_timeout got %b want 1", ok); end
    settle();
    exp = '{8'h7E, 8'h00};
`ifdef MSGFRAMER_TAIL_EN
    exp.push_back(8'h03);
`endif
    checks++;
    if (got.size() - base !== exp.size()) begin errors++; $display("FAIL t4_len got %0d want %0d", got.size() - base, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL t4_byte%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL t4_done_pulses got %0d want 1", done_cnt - dc); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    logic fl, fb, ok, found;
    logic [7:0] fd;
    int base, dc;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    send = 1'b1; tick(1); send = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ld_tx_data && tx_data == 8'h22) begin found = 1'b1; break; end
      tick(1);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL t5_reach_body got %b want 1", found); end
    #2 reset = 1'b0;
    #1;
    checks++; if (ld_tx_data !== 1'b0) begin errors++; $display("FAIL t5_ld_clear got %b want 0", ld_tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_clear got %b want 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL t5_txdata_clear got %h want 00", tx_data); end
    tick(3);
    reset = 1'b1;
    settle();
    base = got.size();
    dc = done_cnt;
    write_byte(8'h99);
    send_wait(1'b0, 8'h00, fl, fd, fb, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t5_done_timeout got %b want 1", ok); end
    settle();
    exp = '{8'h7E, 8'h01, 8'h99};
`ifdef MSGFRAMER_TAIL_EN
    exp.push_back(8'h03);
`endif
    checks++;
    if (got.size() - base !== exp.size()) begin errors++; $display("FAIL t5_len got %0d want %0d", got.size() - base, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL t5_byte%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL t5_done_pulses got %0d want 1", done_cnt - dc); end
  endtask

  task automatic test_stall();
    logic [7:0] exp[$];
    logic ok;
    int bad = 0;
    int base;
    write_byte(8'h5A);
    hold = 1'b1;
    tick(1);
    base = got.size();
    send = 1'b1; tick(1); send = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ld_tx_data || !busy) bad++;
      tick(1);
    end
    checks++; if (bad !== 0 || got.size() !== base) begin errors++; $display("FAIL t6_hold bad=%0d loads=%0d want 0/0", bad, got.size() - base); end
    hold = 1'b0;
    tick(1);
    checks++; if (ld_tx_data !== 1'b1 || tx_data !== 8'h7E) begin errors++; $display("FAIL t6_resume ld=%b data=%h want 1/7e", ld_tx_data, tx_data); end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick(1);
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t6_done_timeout got %b want 1", ok); end
    settle();
    exp = '{8'h7E, 8'h01, 8'h5A};
`ifdef MSGFRAMER_TAIL_EN
    exp.push_back(8'h03);
`endif
    checks++;
    if (got.size() - base !== exp.size()) begin errors++; $display("FAIL t6_len got %0d want %0d", got.size() - base, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[base+i] !== exp[i]) begin errors++; $display("FAIL t6_byte%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL t6_protocol got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_full();
    test_empty();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
